// File: rtl/estacionamiento_if.sv
// Sensor inputs and status/pulse outputs of the parking-lot passage controller.
// The controller uses the slave modport; the driving environment uses master.
interface estacionamiento_if #(
  parameter int WIDTH = 3
) ();
  logic             sens_a;
  logic             sens_b;
  logic             up;
  logic             down;
  logic [WIDTH-1:0] count;
  logic             full;
  logic             empty;
  logic             gate_open;
  logic             denied;
  logic             err;

  modport master (
    output sens_a, sens_b,
    input  up, down, count, full, empty, gate_open, denied, err
  );

  modport slave (
    input  sens_a, sens_b,
    output up, down, count, full, empty, gate_open, denied, err
  );
endinterface

// File: rtl/estacionamiento_ctrl.sv
// Parking-lot passage controller: decodes the two photo-sensor sequence into
// entry/exit events, keeps occupancy, and drives the barrier and event pulses.
module estacionamiento_ctrl #(
  parameter int CAPACITY = 7,
  parameter int WIDTH    = 3,
  parameter int TIMEOUT  = 1000
) (
  input  logic              clk,
  input  logic              reset,
  estacionamiento_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, EN1, EN2, EN3, EX1, EX2, EX3, REJ, ABORT
  } state_t;

  state_t           state, nxt;
  logic             a_p0, a_p1, b_p0, b_p1;
  logic [1:0]       s;
  logic [TW-1:0]    tmr;
  logic [WIDTH-1:0] cnt_n;
  logic             up_n, dn_n, den_n, err_n;

  function automatic logic in_passage(input state_t st);
    return (st == EN1) || (st == EN2) || (st == EN3) ||
           (st == EX1) || (st == EX2) || (st == EX3);
  endfunction

  // Stage p0/p1: two-flop synchronizers for the asynchronous sensors
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_p0 <= 1'b0;
      a_p1 <= 1'b0;
      b_p0 <= 1'b0;
      b_p1 <= 1'b0;
    end else begin
      a_p0 <= bus.sens_a;
      a_p1 <= a_p0;
      b_p0 <= bus.sens_b;
      b_p1 <= b_p0;
    end
  end

  assign s = {a_p1, b_p1};

  always_comb begin
    nxt   = state;
    up_n  = 1'b0;
    dn_n  = 1'b0;
    den_n = 1'b0;
    err_n = 1'b0;
    unique case (state)
      IDLE: case (s)
        2'b10: if (bus.full) begin nxt = REJ; den_n = 1'b1; end else nxt = EN1;
        2'b01: nxt = EX1;
        2'b11: begin nxt = ABORT; err_n = 1'b1; end
        default: ;
      endcase
      EN1: case (s)
        2'b11: nxt = EN2;
        2'b00: nxt = IDLE;
        2'b01: begin nxt = ABORT; err_n = 1'b1; end
        default: ;
      endcase
      EN2: case (s)
        2'b01: nxt = EN3;
        2'b10: nxt = EN1;
        2'b00: begin nxt = ABORT; err_n = 1'b1; end
        default: ;
      endcase
      EN3: case (s)
        2'b00: begin
          nxt = IDLE;
          // A completion at capacity can only follow a race past REJ; flag it.
          if (bus.count == WIDTH'(CAPACITY)) err_n = 1'b1;
          else                               up_n  = 1'b1;
        end
        2'b11: nxt = EN2;
        2'b10: begin nxt = ABORT; err_n = 1'b1; end
        default: ;
      endcase
      EX1: case (s)
        2'b11: nxt = EX2;
        2'b00: nxt = IDLE;
        2'b10: begin nxt = ABORT; err_n = 1'b1; end
        default: ;
      endcase
      EX2: case (s)
        2'b10: nxt = EX3;
        2'b01: nxt = EX1;
        2'b00: begin nxt = ABORT; err_n = 1'b1; end
        default: ;
      endcase
      EX3: case (s)
        2'b00: begin
          nxt = IDLE;
          if (bus.count == '0) err_n = 1'b1;
          else                 dn_n  = 1'b1;
        end
        2'b11: nxt = EX2;
        2'b01: begin nxt = ABORT; err_n = 1'b1; end
        default: ;
      endcase
      REJ, ABORT: if (s == 2'b00) nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // A stalled passage (no state change) aborts once the timer expires.
    if (in_passage(state) && (nxt == state) && (tmr == TW'(TIMEOUT - 1))) begin
      nxt   = ABORT;
      err_n = 1'b1;
    end
    cnt_n = bus.count;
    if (up_n) cnt_n = bus.count + 1'b1;
    if (dn_n) cnt_n = bus.count - 1'b1;
  end

  // Stage p2: state, timer, occupancy and all registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      tmr           <= '0;
      bus.count     <= '0;
      bus.full      <= 1'b0;
      bus.empty     <= 1'b1;
      bus.gate_open <= 1'b0;
      bus.up        <= 1'b0;
      bus.down      <= 1'b0;
      bus.denied    <= 1'b0;
      bus.err       <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt != state || !in_passage(state)) tmr <= '0;
      else                                    tmr <= tmr + 1'b1;
      bus.count     <= cnt_n;
      bus.full      <= (cnt_n == WIDTH'(CAPACITY));
      bus.empty     <= (cnt_n == '0);
      bus.gate_open <= in_passage(nxt);
      bus.up        <= up_n;
      bus.down      <= dn_n;
      bus.denied    <= den_n;
      bus.err       <= err_n;
    end
  end

endmodule

// File: doc/estacionamiento_ctrl.md
ESTACIONAMIENTO_CTRL -- requirements
Module: estacionamiento_ctrl

Interface
REQ-001 SHALL have parameter CAPACITY, default 7, maximum number of parked cars (1..2^WIDTH-1).
REQ-002 SHALL have parameter WIDTH, default 3, occupancy count width.
REQ-003 SHALL have parameter TIMEOUT, default 1000, clock cycles a passage sequence may stall before abort (>=2).
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 SHALL have port sens_a  input  1  outer photo-sensor, 1 = beam blocked; asynchronous to clk.
REQ-007 SHALL have port sens_b  input  1  inner photo-sensor, 1 = beam blocked; asynchronous to clk.
REQ-008 SHALL have port up  output  1  one-cycle pulse, car completed entry (drives counter increment).
REQ-009 SHALL have port down  output  1  one-cycle pulse, car completed exit (drives counter decrement).
REQ-010 SHALL have port count  output  WIDTH  current occupancy.
REQ-011 SHALL have port full  output  1  count == CAPACITY.
REQ-012 SHALL have port empty  output  1  count == 0.
REQ-013 SHALL have port gate_open  output  1  barrier open command.
REQ-014 SHALL have port denied  output  1  one-cycle pulse, entry refused because full.
REQ-015 SHALL have port err  output  1  one-cycle pulse, illegal sensor sequence, timeout, or exit while empty.

Function
REQ-016 SHALL pass sens_a/sens_b through two-flop synchronizers; FSM sees s = {a_s, b_s} two cycles after input change.
REQ-017 SHALL implement states IDLE, EN1, EN2, EN3, EX1, EX2, EX3, REJ, ABORT; all outputs registered.
REQ-018 IDLE: s=10 and !full -> EN1; s=10 and full -> REJ with denied pulse; s=01 -> EX1; s=11 -> ABORT with err pulse; s=00 stay.
REQ-019 EN1: 11 -> EN2; 00 -> IDLE (car backed out, no count change); 01 -> ABORT + err; 10 stay.
REQ-020 EN2: 01 -> EN3; 10 -> EN1; 00 -> ABORT + err; 11 stay.
REQ-021 EN3: 00 -> IDLE with up pulse and count+1; 11 -> EN2; 10 -> ABORT + err; 01 stay.
REQ-022 EX1/EX2/EX3 SHALL mirror EN1/EN2/EN3 with sens_a and sens_b swapped; EX3 -> IDLE on 00 gives down pulse and count-1.
REQ-023 EX3 -> IDLE with count == 0 SHALL give err pulse instead of down; count stays 0.
REQ-024 Entry completion SHALL never raise count above CAPACITY (guaranteed by REJ; if count == CAPACITY at EN3 completion, err instead of up).
REQ-025 REJ and ABORT SHALL return to IDLE only when s=00; no count change; gate_open low.
REQ-026 gate_open SHALL be 1 exactly while state is EN1..EN3 or EX1..EX3.
REQ-027 A stall timer SHALL clear on every state change and count cycles in EN*/EX*; reaching TIMEOUT -> ABORT + err pulse.
REQ-028 up, down, denied, err SHALL each be high for exactly one cycle per event; up and down never high together.
REQ-029 count, up, down SHALL update on the same edge as the completing transition; full/empty SHALL reflect the updated count that same cycle.

Reset
REQ-030 While reset=0: state IDLE, synchronizers 0, timer 0, count=0, empty=1, full=0, gate_open=0, up=down=denied=err=0.
REQ-031 Reset asserted mid-sequence SHALL abandon it with no up/down pulse; after release FSM starts in IDLE.

Verification
REQ-032 Entry 00->10->11->01->00 (each held 5 cycles), count=0 -> one up pulse, count=1, gate_open high during sequence, empty falls.
REQ-033 Seven entries then sens_a=1 -> full=1, denied pulse, gate_open stays 0, count stays 7, REJ until 00.
REQ-034 Exit 00->01->11->10->00 from count=3 -> one down pulse, count=2; same exit at count=0 -> err pulse, count 0.
REQ-035 Entry stopped at 10->11->10->00 (backs out) -> no up, no err, count unchanged, return to IDLE.
REQ-036 Hold s=11 in EN2 for TIMEOUT cycles -> err pulse, gate_open=0, ABORT until 00, count unchanged.
REQ-037 reset=0 during EN3 with count=4 -> count=0, all outputs at reset values, no up pulse after release.
